data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised, byte-addressed data memory for the processor's MEM stage.
- Write path: synchronous 32-bit word writes on the rising clock edge.
- Read path: combinational 32-bit word reads gated by memRead.
- Contents are cleared by an asynchronous active-low reset.

Parameters:
- DEPTH, 64, number of 32-bit words stored; must be a power of two, at least 4.
- ADDR_BITS, 6, word-index width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock; all writes occur on its rising edge.
- RST_N  input  1  asynchronous active-low reset; clears every memory word.
- address  input  32  byte address; bits [1:0] ignored; word index = address[ADDR_BITS+1:2].
- writeData  input  32  word to store when memWrite is high.
- memWrite  input  1  write enable, sampled on the rising CLK edge.
- memRead  input  1  read enable, combinational.
- readData  output  32  word read from memory, or 0.

Behaviour:
- Storage: DEPTH x 32-bit array, indexed by the word index.
- Address decoding:
  - Bits [1:0] are ignored; no misalignment error is raised. Addresses 8, 9, 10 and 11 all select word 2.
  - An address is in range when address[31:ADDR_BITS+2] == 0. Otherwise it is out of range.
- Reset:
  - While RST_N is low, all words are 0 immediately, independent of CLK.
  - Writes are blocked while RST_N is low.
  - Normal operation resumes at the first rising CLK edge after RST_N goes high.
  - Reset asserted mid-operation discards a write pending on the same edge.
- Write:
  - On the rising CLK edge with RST_N high, memWrite=1 and an in-range address, mem[index] <= writeData.
  - All 32 bits are written; there are no byte enables.
  - memWrite=1 with an out-of-range address is ignored; no word changes.
  - memWrite=0 leaves memory unchanged.
- Read:
  - Purely combinational: readData = mem[index] when memRead=1 and the address is in range, otherwise 32'h0.
  - memRead=0 forces readData to 0.
  - Latency: zero cycles; readData follows address and memRead changes within the same cycle.
- Simultaneous read and write to the same word:
  - Before the rising edge, readData shows the old contents.
  - After the edge, readData shows the newly written value in the same cycle; there is no bypass.
- Reset value of readData: 0, since all words are 0.
- memRead and memWrite are independent and may both be high.
- Both enables low is idle: readData=0 and memory is held.
- No X propagation from memory: every word is defined after the first reset.

Test Plan:
- Reset, then read empty location: pulse RST_N low, release; address=14, memRead=1, memWrite=0 -> readData=0.
- Write then read back:
  - Stimulus: address=10, writeData=4, memWrite=1, memRead=1.
  - Before the next rising edge: readData=0.
  - After the edge: readData=4.
  - Then memWrite=0, address=8 -> readData=4 (same word, index 2).
- Read gating: word 2 holds 4; set memRead=0 -> readData=0; set memRead=1 -> readData=4 with no clock edge needed.
- Distinct words and full overwrite:
  - Write 32'hDEADBEEF to address 0 and 32'h12345678 to address 252 (last word, DEPTH=64).
  - Read both back.
  - Overwrite address 0 with 32'h1 -> reads 1; address 252 unchanged.
- Out-of-range access: memWrite=1, address=256, writeData=32'hFFFFFFFF -> no word changes; reading address 256 returns 0; reading address 0 still returns its prior value.
- Asynchronous reset mid-operation:
  - Word 2 holds 4; with CLK steady, drive RST_N low -> readData (address 10, memRead=1) drops to 0 immediately.
  - A write attempted with RST_N low has no effect after release.

Source files
------------

// File: rtl/data_memory.sv
// Word-organised, byte-addressed data memory for the MEM stage.
// Synchronous word writes, combinational gated reads, async clear.
module data_memory #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memWrite,
  input  logic        memRead,
  output logic [31:0] readData
);

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 in_range;
  logic                 unused_bits;

  assign idx         = address[ADDR_BITS+1:2];
  assign in_range    = (address[31:ADDR_BITS+2] == '0);
  // Byte offset is ignored: accesses are always whole words.
  assign unused_bits = ^address[1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWrite && in_range) begin
      mem[idx] <= writeData;
    end
  end

  always_comb begin
    readData = '0;
    if (memRead && in_range) begin
      readData = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory.
// Vectors carry hand-computed expected words.
module tb_data_memory;

  logic        CLK;
  logic        RST_N;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;

  int n_cmp;
  int n_bad;

  data_memory #(
    .DEPTH    (64),
    .ADDR_BITS(6)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .address  (address),
    .writeData(writeData),
    .memWrite (memWrite),
    .memRead  (memRead),
    .readData (readData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    address   = a;
    writeData = d;
    memWrite  = 1'b1;
    @(posedge CLK);
    #1;
    memWrite  = 1'b0;
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    address = a;
    memRead = 1'b1;
    #1;
    check(tag, readData, exp);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    RST_N     = 1'b0;
    address   = '0;
    writeData = '0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    rd_chk("reset_rd14", 32'd14, 32'h0);

    @(negedge CLK);
    address   = 32'd10;
    writeData = 32'd4;
    memWrite  = 1'b1;
    memRead   = 1'b1;
    #1;
    check("wr_before_edge", readData, 32'h0);
    @(posedge CLK);
    #1;
    check("wr_after_edge", readData, 32'd4);
    memWrite = 1'b0;
    rd_chk("alias_addr8", 32'd8, 32'd4);
    rd_chk("alias_addr11", 32'd11, 32'd4);

    memRead = 1'b0;
    #1;
    check("gate_off", readData, 32'h0);
    memRead = 1'b1;
    #1;
    check("gate_on", readData, 32'd4);

    wr(32'd0, 32'hDEADBEEF);
    wr(32'd252, 32'h12345678);
    rd_chk("rd_word0", 32'd0, 32'hDEADBEEF);
    rd_chk("rd_word63", 32'd252, 32'h12345678);
    wr(32'd0, 32'h1);
    rd_chk("overwrite0", 32'd0, 32'h1);
    rd_chk("word63_kept", 32'd255, 32'h12345678);

    wr(32'd256, 32'hFFFFFFFF);
    rd_chk("oor_rd256", 32'd256, 32'h0);
    rd_chk("oor_w0_kept", 32'd0, 32'h1);
    rd_chk("oor_w2_kept", 32'd10, 32'd4);
    rd_chk("oor_w63_kept", 32'd252, 32'h12345678);
    rd_chk("oor_hi_bit", 32'h8000_0000, 32'h0);

    @(negedge CLK);
    address   = 32'd9;
    writeData = 32'd5;
    memWrite  = 1'b1;
    memRead   = 1'b1;
    #1;
    check("rw_same_old", readData, 32'd4);
    @(posedge CLK);
    #1;
    check("rw_same_new", readData, 32'd5);
    memWrite = 1'b0;

    memRead = 1'b0;
    address = 32'd0;
    #1;
    check("idle_zero", readData, 32'h0);
    rd_chk("idle_held", 32'd0, 32'h1);

    @(negedge CLK);
    rd_chk("pre_rst_w2", 32'd10, 32'd5);
    #1;
    RST_N = 1'b0;
    #1;
    check("async_rst_w2", readData, 32'h0);
    writeData = 32'd7;
    memWrite  = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_blocks_wr", readData, 32'h0);
    @(negedge CLK);
    memWrite = 1'b0;
    RST_N    = 1'b1;
    #1;
    check("post_rst_w2", readData, 32'h0);
    rd_chk("post_rst_w0", 32'd0, 32'h0);
    rd_chk("post_rst_w63", 32'd252, 32'h0);

    wr(32'd20, 32'hCAFEF00D);
    rd_chk("resume_wr", 32'd20, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
